// File: rtl/fifo_access_sched_if.sv
// -----------------------------------------------------------------------------
// fifo_access_sched_if
//   Signal bundle between the FIFO access scheduler and its surroundings: two
//   write requesters, the FIFO core's write/read ports and flags, and the
//   single read-data consumer.
//
//   modport master : the scheduler's view (drives readies, FIFO strobes,
//                    write data, consumer data and last_grant).
//   modport slave  : the environment's view (requesters, FIFO core, consumer).
//
//   Parameter WIDTH must match the WIDTH of the scheduler bound to it.
// -----------------------------------------------------------------------------
interface fifo_access_sched_if #(
    parameter int WIDTH = 4
);
    // Requesters
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    // FIFO core
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_wdata;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rdata;

    // Consumer
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Status
    logic             last_grant;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready,
        input  fifo_full, fifo_empty, fifo_rdata,
        output fifo_wr_en, fifo_wdata, fifo_rd_en,
        output out_valid, out_data,
        input  out_ready,
        output last_grant
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready,
        output fifo_full, fifo_empty, fifo_rdata,
        input  fifo_wr_en, fifo_wdata, fifo_rd_en,
        input  out_valid, out_data,
        output out_ready,
        input  last_grant
    );
endinterface

// File: rtl/fifo_access_sched.sv
// -----------------------------------------------------------------------------
// fifo_access_sched
//   Access scheduler in front of a shared FIFO core, all on one clock.
//   - Write side: round-robin arbitration of two requesters onto the FIFO's
//     single write port, combinational within the cycle.
//   - Read side: a four-state FSM issues one-cycle read strobes, paced by a
//     down-counter so issues are at least RD_DIV cycles apart, and hands the
//     returned word to a consumer over valid/ready.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   en     : global enable; low blocks new grants and new read issues
//   bus    : fifo_access_sched_if.master (requesters, FIFO core, consumer,
//            last_grant)
// -----------------------------------------------------------------------------
module fifo_access_sched #(
    parameter int WIDTH  = 4,
    parameter int RD_DIV = 4   // >= 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    fifo_access_sched_if.master         bus
);

    localparam int                PACE_W      = $clog2(RD_DIV);
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(RD_DIV - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_CAPT,
        R_HOLD
    } rd_state_e;

    // -------------------------------------------------------------------------
    // Write arbitration
    // -------------------------------------------------------------------------
    logic gnt0;
    logic gnt1;
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        last_grant_d = last_grant_q;

        // Gating with rst_n keeps the write strobe quiet while in reset.
        if (rst_n && en && !bus.fifo_full) begin
            if (bus.req0_valid && bus.req1_valid) begin
                // Contention: the requester that did not win last time goes.
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end

        if (gnt0) begin
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.fifo_wr_en = gnt0 | gnt1;
    assign bus.fifo_wdata = gnt0 ? bus.req0_data :
                            gnt1 ? bus.req1_data : '0;
    assign bus.last_grant = last_grant_q;

    // -------------------------------------------------------------------------
    // Read pacing and read FSM
    // -------------------------------------------------------------------------
    rd_state_e         state_q;
    rd_state_e         state_d;
    logic [PACE_W-1:0] pace_q;
    logic [PACE_W-1:0] pace_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [WIDTH-1:0]  out_data_q;
    logic [WIDTH-1:0]  out_data_d;
    logic              rd_en;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pace_d      = (pace_q == '0) ? '0 : pace_q - PACE_W'(1);
        rd_en       = 1'b0;

        unique case (state_q)
            R_IDLE: begin
                // Empty and pace are re-evaluated here every cycle, so a read
                // is never issued into an empty FIFO.
                if (en && !bus.fifo_empty && pace_q == '0) begin
                    state_d = R_ISSUE;
                    // Loading on entry makes the counter read RD_DIV-1 during
                    // the strobe cycle, giving exactly RD_DIV cycles between
                    // back-to-back issues.
                    pace_d  = PACE_RELOAD;
                end
            end
            R_ISSUE: begin
                rd_en   = 1'b1;
                state_d = R_CAPT;
            end
            R_CAPT: begin
                // FIFO data is valid the cycle after the strobe.
                out_data_d  = bus.fifo_rdata;
                out_valid_d = 1'b1;
                state_d     = R_HOLD;
            end
            R_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            state_q      <= R_IDLE;
            pace_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            state_q      <= state_d;
            pace_q       <= pace_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // Gated with rst_n so a reset landing on the issue cycle does not pop data
    // that would then be discarded.
    assign bus.fifo_rd_en = rd_en & rst_n;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_fifo_access_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_access_sched
//   Directed bench for fifo_access_sched: reset, round-robin, full
//   back-pressure, read pacing, consumer stall, empty/enable gating, and an
//   end-to-end run against a behavioural 3-deep FIFO with a write-order
//   scoreboard.
// -----------------------------------------------------------------------------
module tb_fifo_access_sched;

    localparam int WIDTH  = 4;
    localparam int RD_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_access_sched_if #(.WIDTH(WIDTH)) bus ();

    fifo_access_sched #(.WIDTH(WIDTH), .RD_DIV(RD_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // FIFO-side stimulus: directly driven, or taken from the behavioural FIFO.
    logic             use_model = 1'b0;
    logic             drv_full  = 1'b0;
    logic             drv_empty = 1'b1;
    logic [WIDTH-1:0] drv_rdata = '0;

    logic [WIDTH-1:0] m_mem [3];
    logic [1:0]       m_wp;
    logic [1:0]       m_rp;
    logic [1:0]       m_cnt;
    logic [WIDTH-1:0] m_rdata;
    logic             m_full;
    logic             m_empty;
    logic             m_wr;
    logic             m_rd;

    assign m_full  = (m_cnt == 2'd3);
    assign m_empty = (m_cnt == 2'd0);
    assign m_wr    = bus.fifo_wr_en && !m_full;
    assign m_rd    = bus.fifo_rd_en && !m_empty;

    assign bus.fifo_full  = use_model ? m_full  : drv_full;
    assign bus.fifo_empty = use_model ? m_empty : drv_empty;
    assign bus.fifo_rdata = use_model ? m_rdata : drv_rdata;

    always @(posedge clk) begin
        if (!use_model) begin
            m_wp    <= 2'd0;
            m_rp    <= 2'd0;
            m_cnt   <= 2'd0;
            m_rdata <= '0;
        end else begin
            if (m_wr) begin
                m_mem[m_wp] <= bus.fifo_wdata;
                m_wp        <= (m_wp == 2'd2) ? 2'd0 : m_wp + 2'd1;
            end
            if (m_rd) begin
                m_rdata <= m_mem[m_rp];
                m_rp    <= (m_rp == 2'd2) ? 2'd0 : m_rp + 2'd1;
            end
            case ({m_wr, m_rd})
                2'b10:   m_cnt <= m_cnt + 2'd1;
                2'b01:   m_cnt <= m_cnt - 2'd1;
                default: m_cnt <= m_cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Helpers (stimulus only)
    // -------------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en             = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.out_ready  = 1'b0;
        drv_full       = 1'b0;
        drv_empty      = 1'b1;
        drv_rdata      = '0;
    endtask

    // Returns one tick after the second reset edge with rst_n released:
    // the current cycle is the first one out of reset ("cycle 0").
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n          = 1'b0;
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 4'hA;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 4'h5;
        drv_empty      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (bus.fifo_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_wr_en[%0d]: got %b expected 0", i, bus.fifo_wr_en);
            end
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, bus.out_valid);
            end
            checks++;
            if (bus.fifo_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_rd_en[%0d]: got %b expected 0", i, bus.fifo_rd_en);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.fifo_wdata} !== {1'b1, 1'b0, 4'hA}) begin
            errors++;
            $display("FAIL reset_first_grant: got r0=%b r1=%b wdata=%h expected r0=1 r1=0 wdata=a",
                     bus.req0_ready, bus.req1_ready, bus.fifo_wdata);
        end
        cyc();
        checks++;
        if (bus.req1_ready !== 1'b1 || bus.last_grant !== 1'b0) begin
            errors++;
            $display("FAIL reset_second_grant: got r1=%b last_grant=%b expected r1=1 last_grant=0",
                     bus.req1_ready, bus.last_grant);
        end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] exp_data;
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 4'hA;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 4'h5;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_data = (k % 2 == 0) ? 4'hA : 4'h5;
            checks++;
            if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wdata !== exp_data) begin
                errors++;
                $display("FAIL rr_wdata[%0d]: got wr_en=%b wdata=%h expected wr_en=1 wdata=%h",
                         k, bus.fifo_wr_en, bus.fifo_wdata, exp_data);
            end
            checks++;
            if (bus.req0_ready !== (k % 2 == 0) || bus.req1_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got r0=%b r1=%b expected r0=%b r1=%b",
                         k, bus.req0_ready, bus.req1_ready, k % 2 == 0, k % 2 == 1);
            end
            checks++;
            if (bus.last_grant !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL rr_last_grant[%0d]: got %b expected %b", k, bus.last_grant, k % 2 == 0);
            end
            cyc();
        end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        bus.req1_valid = 1'b1;
        bus.req1_data  = 4'h7;
        drv_full       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.fifo_wr_en !== 1'b0 || bus.req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_block[%0d]: got wr_en=%b r1=%b expected 0 0",
                         i, bus.fifo_wr_en, bus.req1_ready);
            end
            cyc();
        end
        drv_full = 1'b0;
        #1;
        checks++;
        if ({bus.fifo_wr_en, bus.req1_ready, bus.req0_ready, bus.fifo_wdata} !== {3'b110, 4'h7}) begin
            errors++;
            $display("FAIL full_release: got wr_en=%b r1=%b r0=%b wdata=%h expected 1 1 0 7",
                     bus.fifo_wr_en, bus.req1_ready, bus.req0_ready, bus.fifo_wdata);
        end
    endtask

    task automatic test_read_pacing();
        logic [WIDTH-1:0] exp_data;
        do_reset();
        drv_empty     = 1'b0;
        bus.out_ready = 1'b1;
        // Cycle 0 idle, issues at 1,5,9,..., data held at 3,7,11,...
        for (int i = 0; i < 20; i++) begin
            drv_rdata = WIDTH'(i * 3 + 1);
            #1;
            checks++;
            if (bus.fifo_rd_en !== (i % 4 == 1)) begin
                errors++;
                $display("FAIL pace_rd_en[%0d]: got %b expected %b", i, bus.fifo_rd_en, i % 4 == 1);
            end
            checks++;
            if (bus.out_valid !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL pace_out_valid[%0d]: got %b expected %b", i, bus.out_valid, i % 4 == 3);
            end
            if (i % 4 == 3) begin
                exp_data = WIDTH'((i - 1) * 3 + 1);
                checks++;
                if (bus.out_data !== exp_data) begin
                    errors++;
                    $display("FAIL pace_out_data[%0d]: got %h expected %h", i, bus.out_data, exp_data);
                end
            end
            cyc();
        end
    endtask

    task automatic test_consumer_stall();
        do_reset();
        drv_empty     = 1'b0;
        drv_rdata     = 4'h3;
        bus.out_ready = 1'b0;
        cyc();  // cycle 1: issue
        cyc();  // cycle 2: capture
        cyc();  // cycle 3: first hold cycle
        drv_rdata = 4'hC;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({bus.out_valid, bus.out_data, bus.fifo_rd_en} !== {1'b1, 4'h3, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h rd_en=%b expected 1 3 0",
                         i, bus.out_valid, bus.out_data, bus.fifo_rd_en);
            end
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept_cycle: got valid=%b expected 1", bus.out_valid);
        end
        cyc();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_after_accept: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_empty_enable();
        do_reset();
        drv_empty = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.fifo_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL empty_rd_en[%0d]: got %b expected 0", i, bus.fifo_rd_en);
            end
            cyc();
        end
        drv_empty      = 1'b0;
        en             = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 4'h9;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.fifo_rd_en !== 1'b0 || bus.fifo_wr_en !== 1'b0 || bus.req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL disabled[%0d]: got rd_en=%b wr_en=%b r0=%b expected 0 0 0",
                         i, bus.fifo_rd_en, bus.fifo_wr_en, bus.req0_ready);
            end
            cyc();
        end
        // Enable for one idle cycle, then drop it during the transfer.
        bus.req0_valid = 1'b0;
        en             = 1'b1;
        cyc();
        checks++;
        if (bus.fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL en_issue: got rd_en=%b expected 1", bus.fifo_rd_en);
        end
        en        = 1'b0;
        drv_rdata = 4'h6;
        cyc();
        cyc();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h6) begin
            errors++;
            $display("FAIL en_drop_completes: got valid=%b data=%h expected 1 6",
                     bus.out_valid, bus.out_data);
        end
        // Reset in the hold state discards the word.
        rst_n = 1'b0;
        cyc();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got valid=%b expected 0", bus.out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_end_to_end();
        logic [WIDTH-1:0] sb [$];
        logic [WIDTH-1:0] exp_data;
        int               offers  = 0;
        int               recv    = 0;
        int               bad_ptr = 0;
        int               n_cyc   = 0;
        logic             acc0;
        logic             acc1;

        use_model = 1'b0;
        do_reset();
        use_model = 1'b1;
        while (recv < 150 && n_cyc < 5000) begin
            if (!bus.req0_valid && offers < 150 && $urandom_range(0, 1) == 1) begin
                bus.req0_valid = 1'b1;
                bus.req0_data  = WIDTH'($urandom);
                offers++;
            end
            if (!bus.req1_valid && offers < 150 && $urandom_range(0, 1) == 1) begin
                bus.req1_valid = 1'b1;
                bus.req1_data  = WIDTH'($urandom);
                offers++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);

            @(negedge clk);
            if (bus.fifo_wr_en) sb.push_back(bus.fifo_wdata);
            if (bus.fifo_wr_en && m_full)  bad_ptr++;
            if (bus.fifo_rd_en && m_empty) bad_ptr++;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL e2e_order[%0d]: got %h expected nothing pending", recv, bus.out_data);
                end else begin
                    exp_data = sb.pop_front();
                    if (bus.out_data !== exp_data) begin
                        errors++;
                        $display("FAIL e2e_order[%0d]: got %h expected %h", recv, bus.out_data, exp_data);
                    end
                end
                recv++;
            end
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;

            cyc();
            if (acc0) bus.req0_valid = 1'b0;
            if (acc1) bus.req1_valid = 1'b0;
            n_cyc++;
        end
        checks++;
        if (recv != 150 || sb.size() != 0) begin
            errors++;
            $display("FAIL e2e_count: got %0d received, %0d pending expected 150 received, 0 pending",
                     recv, sb.size());
        end
        checks++;
        if (bad_ptr != 0) begin
            errors++;
            $display("FAIL e2e_over_underflow: got %0d events expected 0", bad_ptr);
        end
        use_model = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full_backpressure();
        test_read_pacing();
        test_consumer_stall();
        test_empty_enable();
        test_end_to_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_access_sched.md
Name: fifo_access_sched

Overview:
- Access scheduler for the shared 4-bit FIFO datapath.
- Arbitrates two write requesters onto the FIFO's single write port using round-robin.
- Paces reads from the FIFO with a programmable cycle divider, replacing the separate write/read divided clocks with enables.
- Presents read data to one consumer through a valid/ready handshake.
- Sits between the producers/consumer and the FIFO core, all on the single system clock.

Parameters:
- WIDTH, 4, data width of requester, FIFO and consumer data paths.
- RD_DIV, 4, minimum cycles between FIFO read issues (≥2); pace counter width is clog2(RD_DIV).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- en  input  1  global enable; low blocks new grants and new read issues.
- req0_valid  input  1  requester 0 has data.
- req0_data  input  WIDTH  requester 0 data.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid  input  1  requester 1 has data.
- req1_data  input  WIDTH  requester 1 data.
- req1_ready  output  1  requester 1 write accepted this cycle.
- fifo_full  input  1  FIFO full flag.
- fifo_empty  input  1  FIFO empty flag.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_wdata  output  WIDTH  FIFO write data.
- fifo_rd_en  output  1  FIFO read strobe; FIFO presents fifo_rdata the cycle after.
- fifo_rdata  input  WIDTH  FIFO read data.
- out_valid  output  1  consumer data valid.
- out_data  output  WIDTH  consumer data.
- out_ready  input  1  consumer accepts.
- last_grant  output  1  ID of most recently granted requester.

Behaviour:

Reset (rst_n low at a clock edge):
- last_grant=1, so requester 0 has first priority.
- pace counter=0, read FSM=R_IDLE.
- out_valid=0, out_data=0, fifo_rd_en=0.
- Write-side outputs are combinational and read 0 while rst_n is low.

Write arbitration (combinational, same cycle):
- A grant is possible when en=1, fifo_full=0 and at least one reqN_valid=1.
- If only one requester is valid, it wins.
- If both are valid, the requester not equal to last_grant wins.
- The winner gets reqN_ready=1, fifo_wr_en=1 and fifo_wdata=reqN_data.
- fifo_wdata=0 when there is no grant.
- last_grant updates to the winner at the clock edge.
- reqN_ready never asserts without reqN_valid, and never while fifo_full=1.
- At most one write per cycle.

Read pacing:
- The pace counter decrements to 0 each cycle and saturates at 0.
- It reloads to RD_DIV-1 on the cycle fifo_rd_en=1.

Read FSM:
- R_IDLE: when en=1, fifo_empty=0 and pace=0, go to R_ISSUE.
- R_ISSUE: fifo_rd_en=1 for exactly this one cycle; go to R_CAPT.
- R_CAPT: register fifo_rdata into out_data and set out_valid=1; go to R_HOLD.
- R_HOLD: hold out_valid and out_data stable until out_ready=1. On that cycle, clear out_valid and go to R_IDLE.

Read timing and boundary rules:
- Minimum latency is 2 cycles from R_IDLE exit to out_valid.
- The next issue comes no earlier than max(RD_DIV, handshake completion) cycles after the previous issue.
- Simultaneous FIFO write and read in the same cycle are allowed; the two sides are independent.
- fifo_rd_en never asserts while fifo_empty=1 (the state is re-checked in R_IDLE).
- en dropping while in R_ISSUE, R_CAPT or R_HOLD does not abort the transfer; it completes.
- rst_n low mid-transfer discards held data: out_valid=0 on the next edge.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with both requesters valid -> fifo_wr_en=0, out_valid=0 and fifo_rd_en=0 throughout; after release, first grant goes to requester 0.
- Round-robin: both valid continuously, fifo_full=0, data 4'hA and 4'h5 -> fifo_wdata sequence A,5,A,5; req0_ready and req1_ready alternate each cycle.
- Full back-pressure: fifo_full=1 for 3 cycles with req1_valid=1 -> no fifo_wr_en and req1_ready=0 for those cycles; write issues on the first cycle fifo_full=0.
- Read pacing: fifo_empty=0, out_ready=1, RD_DIV=4 -> fifo_rd_en pulses exactly every 4 cycles; out_data equals fifo_rdata sampled the cycle after each pulse.
- Consumer stall: out_ready=0 for 5 cycles with fifo_rdata=4'h3 -> out_valid=1 and out_data=3 held stable, no further fifo_rd_en; one cycle after out_ready=1, out_valid=0.
- Empty/enable and end-to-end: fifo_empty=1 or en=0 -> fifo_rd_en never asserts. Behavioural 3-deep FIFO model, 150 random writes -> out_data order matches write order, with no overflow and no underflow.
